// File: rtl/memory_stage_pipelined.sv
// -----------------------------------------------------------------------------
// memory_stage_pipelined
//   Memory (M) stage of the barrel RISC-V core, between execute and writeback.
//   Takes one E-stage op per clock and performs byte/half/word loads and stores
//   against an internal word-organised data RAM. Results appear LATENCY clocks
//   later (1 or 2). Loads are sign/zero extended. Misaligned, out-of-range and
//   illegal-funct3 accesses raise fault_m, which suppresses the register write
//   and zeroes the load data.
//
// Ports
//   clk, reset                      rising-edge clock, async active-high reset
//   valid_e, reg_write_e            E-stage op valid / op writes rd
//   result_src_e[1:0]               01 selects load result, other codes pass
//   mem_write_e                     store (wins over result_src_e == 01)
//   funct3_e[2:0]                   access size / signedness
//   alu_result_e, write_data_e      byte address, store data
//   rd_e, pc_plus4_e, tid_e         sideband carried to the M outputs
//   valid_m .. tid_m, fault_m       registered M-stage results
// -----------------------------------------------------------------------------
module memory_stage_pipelined #(
    parameter int  ADDRESS_WIDTH = 32,
    parameter int  DATA_WIDTH    = 32,
    parameter int  DMEM_SIZE     = 64,
    parameter int  NUM_THREADS   = 4,
    parameter int  LATENCY       = 1,
    localparam int BITS_THREADS  = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_e,
    input  logic                     reg_write_e,
    input  logic [1:0]               result_src_e,
    input  logic                     mem_write_e,
    input  logic [2:0]               funct3_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_e,
    input  logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [4:0]               rd_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    output logic                     valid_m,
    output logic                     reg_write_m,
    output logic [1:0]               result_src_m,
    output logic [DATA_WIDTH-1:0]    alu_result_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic [4:0]               rd_m,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    output logic [BITS_THREADS-1:0]  tid_m,
    output logic                     fault_m
);

    localparam int IDX_W = $clog2(DMEM_SIZE);
    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(DMEM_SIZE * 4);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("memory_stage_pipelined: only DATA_WIDTH = 32 is supported");
        end
        if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
            $error("memory_stage_pipelined: LATENCY must be 1 or 2");
        end
        if (DMEM_SIZE < 2 || (DMEM_SIZE & (DMEM_SIZE - 1)) != 0) begin : g_bad_dmem
            $error("memory_stage_pipelined: DMEM_SIZE must be a power of 2, >= 2");
        end
    endgenerate

    typedef struct packed {
        logic                     valid;
        logic                     reg_write;
        logic [1:0]               result_src;
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    read_data;
        logic [4:0]               rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        logic [BITS_THREADS-1:0]  tid;
        logic                     fault;
    } stage_t;

    // Pick the addressed byte/half lane out of a RAM word and extend it.
    function automatic logic [31:0] f_load_extend(input logic [31:0] word,
                                                  input logic [1:0]  lane,
                                                  input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    logic [31:0]      r_mem [DMEM_SIZE];
    logic [IDX_W-1:0] w_idx;
    logic             w_access;
    logic             w_is_store;
    logic             w_is_load;
    logic             w_funct_ok;
    logic             w_misalign;
    logic             w_out_of_range;
    logic             w_fault;
    stage_t           w_stage_e;
    stage_t           r_stage_p0;
    stage_t           w_stage_out;

    assign w_idx = alu_result_e[IDX_W+1:2];

    always_comb begin
        w_access   = valid_e && (mem_write_e || result_src_e == 2'b01);
        w_is_store = valid_e && mem_write_e;
        w_is_load  = valid_e && !mem_write_e && (result_src_e == 2'b01);
        case (funct3_e)
            3'b000, 3'b001, 3'b010: w_funct_ok = 1'b1;
            3'b100, 3'b101:         w_funct_ok = !mem_write_e;
            default:                w_funct_ok = 1'b0;
        endcase
        // funct3[1:0]==01 covers both H and HU
        w_misalign = ((funct3_e[1:0] == 2'b01) && alu_result_e[0]) ||
                     ((funct3_e == 3'b010) && (alu_result_e[1:0] != 2'b00));
        // full-width compare so high addresses never alias into the RAM
        w_out_of_range = (alu_result_e >= MEM_BYTES);
        w_fault = w_access && (!w_funct_ok || w_misalign || w_out_of_range);

        w_stage_e            = '0;
        w_stage_e.valid      = valid_e;
        w_stage_e.reg_write  = reg_write_e && !w_fault;
        w_stage_e.result_src = result_src_e;
        w_stage_e.alu_result = alu_result_e;
        // RAM is read combinationally, so a store committed on the previous
        // edge is already visible to a load in this cycle.
        w_stage_e.read_data  = (w_is_load && !w_fault)
                             ? f_load_extend(r_mem[w_idx], alu_result_e[1:0], funct3_e)
                             : '0;
        w_stage_e.rd         = rd_e;
        w_stage_e.pc_plus4   = pc_plus4_e;
        w_stage_e.tid        = tid_e;
        w_stage_e.fault      = w_fault;
    end

    // Byte-enabled store; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_is_store && !w_fault) begin
            case (funct3_e[1:0])
                2'b00:   r_mem[w_idx][{alu_result_e[1:0], 3'b000} +: 8]  <= write_data_e[7:0];
                2'b01:   r_mem[w_idx][{alu_result_e[1], 4'b0000} +: 16] <= write_data_e[15:0];
                default: r_mem[w_idx]                                   <= write_data_e[31:0];
            endcase
        end
    end

    // ---- E -> p0 ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_stage_p0 <= '0;
        else       r_stage_p0 <= w_stage_e;
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            stage_t r_stage_p1;
            // ---- p0 -> p1 ----
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_stage_p1 <= '0;
                else       r_stage_p1 <= r_stage_p0;
            end
            assign w_stage_out = r_stage_p1;
        end else begin : g_lat1
            assign w_stage_out = r_stage_p0;
        end
    endgenerate

    assign valid_m      = w_stage_out.valid;
    assign reg_write_m  = w_stage_out.reg_write;
    assign result_src_m = w_stage_out.result_src;
    assign alu_result_m = w_stage_out.alu_result;
    assign read_data_m  = w_stage_out.read_data;
    assign rd_m         = w_stage_out.rd;
    assign pc_plus4_m   = w_stage_out.pc_plus4;
    assign tid_m        = w_stage_out.tid;
    assign fault_m      = w_stage_out.fault;

endmodule

// File: tb/tb_memory_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_memory_stage_pipelined
//   Self-checking bench for memory_stage_pipelined (LATENCY = 2, DMEM_SIZE = 64).
//   A byte-array reference model predicts every M-stage output; directed ops
//   additionally carry literal expected values.
// -----------------------------------------------------------------------------
module tb_memory_stage_pipelined;

    localparam int LAT  = 2;
    localparam int DMEM = 64;
    localparam int MEMB = DMEM * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_e, reg_write_e, mem_write_e;
    logic [1:0]  result_src_e;
    logic [2:0]  funct3_e;
    logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
    logic [4:0]  rd_e;
    logic [1:0]  tid_e;
    logic        valid_m, reg_write_m, fault_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic [1:0]  tid_m;

    memory_stage_pipelined #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DMEM_SIZE(DMEM),
        .NUM_THREADS(4), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .reg_write_e(reg_write_e),
        .result_src_e(result_src_e), .mem_write_e(mem_write_e), .funct3_e(funct3_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .rd_e(rd_e),
        .pc_plus4_e(pc_plus4_e), .tid_e(tid_e), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .alu_result_m(alu_result_m), .read_data_m(read_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .tid_m(tid_m), .fault_m(fault_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v, rw, mw;
        bit [1:0]  rs;
        bit [2:0]  f3;
        bit [31:0] addr, wd, pc;
        bit [4:0]  rd;
        bit [1:0]  tid;
        bit        hc;   // literal expectation attached
        bit [31:0] cv;   // literal read_data
        bit        cf;   // literal fault
    } op_t;

    typedef struct {
        op_t       op;
        bit        rw, fault;
        bit [31:0] rdata;
    } exp_t;

    int        n_tests = 0;
    int        n_fail  = 0;
    bit [7:0]  mref [MEMB];
    exp_t      exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain byte-addressed memory, sizes in bytes.
    function automatic exp_t model(input op_t op);
        exp_t      e;
        int        sz;
        bit        acc, st, ld, legal, flt;
        bit [31:0] val;
        e.op = op;
        acc = op.v && (op.mw || op.rs == 2'b01);
        st  = op.v && op.mw;
        ld  = op.v && !op.mw && op.rs == 2'b01;
        case (op.f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 1;
        endcase
        legal = (op.f3 <= 3'd2) || (!op.mw && (op.f3 == 3'd4 || op.f3 == 3'd5));
        flt = acc && (!legal || (op.addr % sz) != 0 || op.addr >= MEMB);
        val = 0;
        if (st && !flt)
            for (int i = 0; i < sz; i++) mref[int'(op.addr) + i] = 8'(op.wd >> (8 * i));
        if (ld && !flt) begin
            for (int i = 0; i < sz; i++) val |= 32'(mref[int'(op.addr) + i]) << (8 * i);
            if (op.f3 < 3'd4 && sz < 4 && val[8 * sz - 1]) val |= ~((32'h1 << (8 * sz)) - 1);
        end
        e.fault = flt;
        e.rw    = op.rw && !flt;
        e.rdata = val;
        return e;
    endfunction

    function automatic op_t mk(input bit mw, input bit [1:0] rs, input bit [2:0] f3,
                               input bit [31:0] addr, input bit [31:0] wd);
        op_t o;
        o.v = 1; o.rw = !mw; o.mw = mw; o.rs = rs; o.f3 = f3; o.addr = addr; o.wd = wd;
        o.pc = $urandom; o.rd = 5'($urandom); o.tid = 2'($urandom);
        o.hc = 0; o.cv = 0; o.cf = 0;
        return o;
    endfunction

    function automatic op_t mkc(input op_t o, input bit [31:0] cv, input bit cf);
        op_t r = o;
        r.hc = 1; r.cv = cv; r.cf = cf;
        return r;
    endfunction

    task automatic check_out(input exp_t e);
        chk("valid_m", valid_m, e.op.v);
        if (e.op.v) begin
            chk("reg_write_m", reg_write_m, e.rw);
            chk("result_src_m", result_src_m, e.op.rs);
            chk("alu_result_m", alu_result_m, e.op.addr);
            chk("read_data_m", read_data_m, e.rdata);
            chk("rd_m", rd_m, e.op.rd);
            chk("pc_plus4_m", pc_plus4_m, e.op.pc);
            chk("tid_m", tid_m, e.op.tid);
            chk("fault_m", fault_m, e.fault);
            if (e.op.hc) begin
                chk("lit_read_data", read_data_m, e.op.cv);
                chk("lit_fault", fault_m, e.op.cf);
                if (e.op.cf) chk("lit_reg_write", reg_write_m, 1'b0);
            end
        end
    endtask

    // One clock: check the op issued LAT cycles ago, then drive the next op.
    task automatic step(input op_t op);
        @(negedge clk);
        if (exp_q.size() == LAT) check_out(exp_q.pop_front());
        valid_e = op.v; reg_write_e = op.rw; mem_write_e = op.mw; result_src_e = op.rs;
        funct3_e = op.f3; alu_result_e = op.addr; write_data_e = op.wd;
        rd_e = op.rd; pc_plus4_e = op.pc; tid_e = op.tid;
        exp_q.push_back(model(op));
    endtask

    function automatic op_t idle();
        op_t o = mk(0, 2'b00, 3'd0, 32'h0, 32'h0);
        o.v = 0;
        return o;
    endfunction

    task automatic drain();
        for (int i = 0; i < LAT; i++) step(idle());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t o;
        reset = 1'b1;
        valid_e = 0; reg_write_e = 0; mem_write_e = 0; result_src_e = 0;
        funct3_e = 0; alu_result_e = 0; write_data_e = 0; rd_e = 0; pc_plus4_e = 0; tid_e = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid_m", valid_m, 0);
        chk("rst_reg_write_m", reg_write_m, 0);
        chk("rst_read_data_m", read_data_m, 0);
        chk("rst_alu_result_m", alu_result_m, 0);
        chk("rst_pc_plus4_m", pc_plus4_m, 0);
        chk("rst_fault_m", fault_m, 0);
        reset = 1'b0;

        // Give every RAM word a known value.
        for (int w = 0; w < DMEM; w++) step(mk(1, 2'b00, 3'd2, 32'(w * 4), $urandom));

        // Directed accesses with literal expectations.
        step(mk(1, 2'b00, 3'd2, 32'h10, 32'hDEADBEEF));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h10, 0), 32'hDEADBEEF, 0));
        step(mkc(mk(0, 2'b01, 3'd0, 32'h13, 0), 32'hFFFFFFDE, 0));
        step(mkc(mk(0, 2'b01, 3'd4, 32'h13, 0), 32'h000000DE, 0));
        step(mkc(mk(0, 2'b01, 3'd1, 32'h12, 0), 32'hFFFFDEAD, 0));
        step(mkc(mk(0, 2'b01, 3'd5, 32'h10, 0), 32'h0000BEEF, 0));
        step(mk(1, 2'b00, 3'd0, 32'h11, 32'h00000055));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h10, 0), 32'hDEAD55EF, 0));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h12, 0), 32'h0, 1));
        step(mkc(mk(1, 2'b00, 3'd1, 32'h11, 32'h1234), 32'h0, 1));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h100, 0), 32'h0, 1));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h10, 0), 32'hDEAD55EF, 0));
        step(mkc(mk(1, 2'b00, 3'd4, 32'h14, 32'hFF), 32'h0, 1));
        step(mkc(mk(0, 2'b01, 3'd3, 32'h14, 0), 32'h0, 1));
        step(mkc(mk(0, 2'b01, 3'd2, 32'hFFFF_FF10, 0), 32'h0, 1));
        drain();

        // Asynchronous reset with two stores in flight.
        step(mk(1, 2'b00, 3'd2, 32'h20, 32'h11223344));
        step(mk(1, 2'b00, 3'd2, 32'h24, 32'hA5A55A5A));
        @(posedge clk);
        #1 valid_e = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_valid_m", valid_m, 0);
        chk("async_reg_write_m", reg_write_m, 0);
        chk("async_alu_result_m", alu_result_m, 0);
        chk("async_rd_m", rd_m, 0);
        chk("async_tid_m", tid_m, 0);
        chk("async_pc_plus4_m", pc_plus4_m, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("held_valid_m", valid_m, 0);
        reset = 1'b0;
        step(mkc(mk(0, 2'b01, 3'd2, 32'h20, 0), 32'h11223344, 0));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h24, 0), 32'hA5A55A5A, 0));
        step(mkc(mk(0, 2'b01, 3'd2, 32'h10, 0), 32'hDEAD55EF, 0));
        drain();

        // Randomised back-to-back traffic, threads interleaved 0..3.
        for (int i = 0; i < 400; i++) begin
            int sel;
            o = mk($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 32'($urandom_range(0, MEMB - 1)), $urandom);
            sel = $urandom_range(0, 19);
            if (sel == 0) o.addr = 32'($urandom_range(MEMB, MEMB + 40));
            else if (sel == 1) o.addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0 && o.f3 inside {3'd1, 3'd2, 3'd5}) o.addr &= ~32'(o.f3[1] ? 3 : 1);
            o.tid = 2'(i % 4);
            o.rw  = 1'($urandom);
            if (i > 300 && $urandom_range(0, 9) == 0) o.v = 0;
            step(o);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
